serial_subtractor: RTL and testbench

- Bit-serial WIDTH-bit subtractor with borrow-in. It is the inverse-direction counterpart of the team's parallel ripple adder on the XC2 CPLD.
- It computes a - b - bin one bit per clock, LSB first, using a single full-subtractor cell.
- This trades latency for macrocell count.
- Operands are presented on parallel pins with a start/busy/done handshake. The result is delivered on parallel pins for the OBUF-driven outputs.

---
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Operand/result bundle for serial_subtractor.
//               zero/ovf exist only when SERIAL_SUB_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, bout, zero, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout, zero, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, bout);
    modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b - bin, LSB first, one full-subtractor cell.
//               Optional zero/ovf flags under macro SERIAL_SUB_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sb_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             br_q, bout_q;
    logic             w_d, w_br_next, w_last, w_accept;
    logic             w_busy, w_done;
    logic [WIDTH-1:0] w_res_full;

    assign w_d        = sa_q[0] ^ sb_q[0] ^ br_q;
    assign w_br_next  = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign w_last     = (cnt_q == CW'(WIDTH - 1));
    assign w_res_full = {w_d, res_q[WIDTH-1:1]};
    assign w_accept   = bus.start && (state_q == c_IDLE || state_q == c_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= c_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (bus.start) state_d = c_SHIFT;
            c_SHIFT: if (w_last)    state_d = c_DONE;
            c_DONE:  state_d = bus.start ? c_SHIFT : c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    // Output decode; both come straight from the state flops
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (state_q)
            c_SHIFT: w_busy = 1'b1;
            c_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            br_q   <= 1'b0;
            res_q  <= '0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
        end else if (w_accept) begin
            sa_q  <= bus.a;
            sb_q  <= bus.b;
            br_q  <= bus.bin;
            res_q <= '0;
            cnt_q <= '0;
        end else if (state_q == c_SHIFT) begin
            sa_q  <= sa_q >> 1;
            sb_q  <= sb_q >> 1;
            br_q  <= w_br_next;
            res_q <= w_res_full;
            cnt_q <= cnt_q + CW'(1);
            if (w_last) begin
                diff_q <= w_res_full;
                bout_q <= w_br_next;
            end
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero_q, ovf_q;

    // On the last SHIFT cycle sa_q[0]/sb_q[0] hold the original operand MSBs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (!w_accept && state_q == c_SHIFT && w_last) begin
            zero_q <= (w_res_full == '0);
            ovf_q  <= (sa_q[0] != sb_q[0]) && (w_d != sa_q[0]);
        end
    end

    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`endif

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor (WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
    localparam int WIDTH = 4;

    typedef struct {
        logic [3:0] diff;
        logic       bout;
        logic       zero;
        logic       ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t q[$];

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", {28'd0, bus.diff}, {28'd0, e.diff});
                chk("bout", {31'd0, bus.bout}, {31'd0, e.bout});
`ifdef SERIAL_SUB_FLAGS_EN
                chk("zero", {31'd0, bus.zero}, {31'd0, e.zero});
                chk("ovf",  {31'd0, bus.ovf},  {31'd0, e.ovf});
`endif
            end
        end
    end

    task automatic push(input logic [3:0] d, input logic bo, input logic z, input logic o);
        exp_t e;
        e.diff = d; e.bout = bo; e.zero = z; e.ovf = o;
        q.push_back(e);
    endtask

    // Drives start for one edge; returns at the negedge after the accepting edge
    task automatic issue(input logic [3:0] ia, input logic [3:0] ib, input logic ibin,
                         input logic [3:0] ed, input logic eb, input logic ez, input logic eo);
        @(negedge clk);
        bus.start = 1'b1; bus.a = ia; bus.b = ib; bus.bin = ibin;
        push(ed, eb, ez, eo);
        @(negedge clk);
        bus.start = 1'b0; bus.a = ~ia; bus.b = ~ib; bus.bin = ~ibin;
    endtask

    // lat = clock edges after the accepting edge until done is seen
    task automatic wait_done(output int lat, output int nb);
        lat = 0;
        nb  = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) nb++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int lat, nb, extra;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_diff", {28'd0, bus.diff}, 32'd0);
        chk("rst_bout", {31'd0, bus.bout}, 32'd0);
        rst_n = 1'b1;

        // 9 - 3 = 6; signed -7 - 3 overflows
        issue(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b0, 1'b1);
        wait_done(lat, nb);
        chk("latency_9_3", lat, 32'd4);
        chk("busy_cycles", nb, 32'd4);

        // 3 - 9 = 0xA with borrow; signed 3 - (-7) = 10 overflows
        issue(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b0, 1'b1);
        wait_done(lat, nb);

        issue(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0);
        wait_done(lat, nb);

        issue(4'd7, 4'd7, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        wait_done(lat, nb);

        // start while busy must be ignored
        issue(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b1; bus.a = 4'd1; bus.b = 4'd1; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat, nb);
        chk("latency_ignore", lat, 32'd3);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        chk("single_done", extra, 32'd0);

        // Back-to-back with start held high
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'hF; bus.b = 4'h1; bus.bin = 1'b0;
        repeat (3) push(4'hE, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            wait_done(lat, nb);
            chk("b2b_spacing", lat, 32'd4);
            if (k < 2) begin
                @(negedge clk);
                chk("b2b_no_gap", {31'd0, bus.busy}, 32'd1);
            end else begin
                bus.start = 1'b0;
            end
        end

        // Asynchronous reset at cnt == 2
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd3; bus.bin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.done}, 32'd0);
        chk("arst_diff", {28'd0, bus.diff}, 32'd0);
        chk("arst_bout", {31'd0, bus.bout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 8 - 1 - 1 = 6; signed -8 - 1 - 1 overflows
        issue(4'd8, 4'd1, 1'b1, 4'd6, 1'b0, 1'b0, 1'b1);
        wait_done(lat, nb);
        chk("latency_after_rst", lat, 32'd4);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
